// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified stereo transmitter with a one-pair holding register.
// Optional build macro I2S_TX_MONO_MIX_EN adds a mono input that mixes L/R into both slots.
module i2s_tx #(
    parameter int CLK_HZ      = 32000000,
    parameter int SAMPLE_RATE = 24000,
    parameter int SAMPLE_W    = 16,
    parameter int SLOT_W      = 16,
    parameter int OFFSET_BIN  = 1
) (
    input  logic                clk32,
    input  logic                por,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                fmt_i2s,
    input  logic                mute,
`ifdef I2S_TX_MONO_MIX_EN
    input  logic                mono,
`endif
    output logic                i2s_bck,
    output logic                i2s_ws,
    output logic                i2s_din,
    output logic                frame_strobe,
    output logic                underrun
);

    localparam int DIV   = CLK_HZ / (SAMPLE_RATE * 2 * SLOT_W * 2);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW    = 2 * SLOT_W;
    localparam int BW    = $clog2(FW);

    if (DIV < 1) begin : g_bad_div
        $error("i2s_tx: DIV < 1, clk32 too slow for SAMPLE_RATE and SLOT_W");
    end
    if (SLOT_W < SAMPLE_W) begin : g_bad_slot
        $error("i2s_tx: SLOT_W must be >= SAMPLE_W");
    end

    // Slot image: sample MSB-first (MSB optionally inverted), zero padded on the right.
    function automatic logic [SLOT_W-1:0] enc(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] t;
        t = s;
        t[SAMPLE_W-1] = t[SAMPLE_W-1] ^ (OFFSET_BIN != 0);
        return SLOT_W'(t) << (SLOT_W - SAMPLE_W);
    endfunction

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d, nxt_bit;
    logic                bck_q, bck_d, ws_q, ws_d, din_q, din_d;
    logic                strobe_q, strobe_d, underrun_q, underrun_d;
    logic                ready_q, ready_d, full_q, full_d, fmt_q, fmt_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, src_l, src_r;
    logic [FW-1:0]       frame_q, frame_d, lj_word, i2s_word;
    logic                tick, fall, load, handshake;
`ifdef I2S_TX_MONO_MIX_EN
    logic [SAMPLE_W:0]   mix_sum;
`endif

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        fall      = tick && bck_q;
        load      = fall && (bit_cnt_q == BW'(FW - 1));
        nxt_bit   = (bit_cnt_q == BW'(FW - 1)) ? '0 : bit_cnt_q + BW'(1);
        handshake = sample_valid && ready_q;

        src_l = hold_l_q;
        src_r = hold_r_q;
`ifdef I2S_TX_MONO_MIX_EN
        mix_sum = {hold_l_q[SAMPLE_W-1], hold_l_q} + {hold_r_q[SAMPLE_W-1], hold_r_q};
        if (mono) begin
            src_l = mix_sum[SAMPLE_W:1];
            src_r = mix_sum[SAMPLE_W:1];
        end
`endif
        if (mute) begin
            src_l = '0;
            src_r = '0;
        end

        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        bck_d      = tick ? ~bck_q : bck_q;
        bit_cnt_d  = fall ? nxt_bit : bit_cnt_q;
        frame_d    = frame_q;
        fmt_d      = fmt_q;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        strobe_d   = load;
        underrun_d = load && !full_q;

        if (load) begin
            fmt_d = fmt_i2s;
            if (full_q || mute) frame_d = {enc(src_l), enc(src_r)};
            full_d = 1'b0;
        end
        if (handshake) begin
            hold_l_d = audio_l;
            hold_r_d = audio_r;
            full_d   = 1'b1;
        end
        ready_d = !full_d;

        // Bit 0 of an I2S frame still carries the outgoing frame's last bit, hence frame_q.
        ws_d     = ws_q;
        din_d    = din_q;
        lj_word  = frame_d << nxt_bit;
        i2s_word = frame_d << (nxt_bit - BW'(1));
        if (fall) begin
            ws_d = (nxt_bit >= BW'(SLOT_W));
            if (!fmt_d)               din_d = lj_word[FW-1];
            else if (nxt_bit == '0)   din_d = frame_q[0];
            else                      din_d = i2s_word[FW-1];
        end
    end

    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            bck_q      <= 1'b0;
            ws_q       <= 1'b0;
            din_q      <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            full_q     <= 1'b0;
            fmt_q      <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            frame_q    <= {enc('0), enc('0)};
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bck_q      <= bck_d;
            ws_q       <= ws_d;
            din_q      <= din_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            full_q     <= full_d;
            fmt_q      <= fmt_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_q    <= frame_d;
        end
    end

    assign sample_ready = ready_q;
    assign i2s_bck      = bck_q;
    assign i2s_ws       = ws_q;
    assign i2s_din      = din_q;
    assign frame_strobe = strobe_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a linear (OFFSET_BIN=0) and an offset-binary instance share all inputs;
// each frame is decoded from the serial pins and compared with a frame-level model.
module tb_i2s_tx;

    logic        clk32 = 1'b0;
    logic        por, sample_valid, fmt_i2s, mute;
    logic [15:0] audio_l, audio_r;
    logic        rdy_a, bck_a, ws_a, din_a, stb_a, ur_a;
    logic        rdy_b, bck_b, ws_b, din_b, stb_b, ur_b;
`ifdef I2S_TX_MONO_MIX_EN
    logic        mono = 1'b0;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Model state: raw word pair in the shift register, and the pair waiting in holding.
    logic [31:0] prev_w = '0;
    logic [31:0] held_w = '0;
    bit          held_valid = 1'b0;

    always #5 clk32 = ~clk32;

    i2s_tx #(.OFFSET_BIN(0)) dut_lin (
        .clk32(clk32), .por(por), .audio_l(audio_l), .audio_r(audio_r),
        .sample_valid(sample_valid), .sample_ready(rdy_a), .fmt_i2s(fmt_i2s), .mute(mute),
`ifdef I2S_TX_MONO_MIX_EN
        .mono(mono),
`endif
        .i2s_bck(bck_a), .i2s_ws(ws_a), .i2s_din(din_a), .frame_strobe(stb_a), .underrun(ur_a)
    );

    i2s_tx #(.OFFSET_BIN(1)) dut_ob (
        .clk32(clk32), .por(por), .audio_l(audio_l), .audio_r(audio_r),
        .sample_valid(sample_valid), .sample_ready(rdy_b), .fmt_i2s(fmt_i2s), .mute(mute),
`ifdef I2S_TX_MONO_MIX_EN
        .mono(mono),
`endif
        .i2s_bck(bck_b), .i2s_ws(ws_b), .i2s_din(din_b), .frame_strobe(stb_b), .underrun(ur_b)
    );

    function automatic logic [31:0] pair_word(input logic [15:0] l, input logic [15:0] r);
        int s;
        logic [31:0] w;
        w = {l, r};
`ifdef I2S_TX_MONO_MIX_EN
        if (mono) begin
            s = ($signed(l) + $signed(r)) >>> 1;
            w = {s[15:0], s[15:0]};
        end
`endif
        s = 0;
        return w;
    endfunction

    task automatic wait_strobe(output bit ok);
        logic p;
        p  = stb_a;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk32);
            if (stb_a && !p) begin
                ok = 1'b1;
                break;
            end
            p = stb_a;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_timeout: no frame_strobe within 3000 cycles, required one");
        end
    endtask

    task automatic wait_bck_rise(output bit ok);
        logic p;
        p  = bck_a;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk32);
            if (bck_a && !p) begin
                ok = 1'b1;
                break;
            end
            p = bck_a;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL bck_timeout: no i2s_bck rise within 200 cycles, required one");
        end
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        for (int n = 0; n < 100 && !rdy_a; n++) @(negedge clk32);
        vectors++;
        if (rdy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: sample_ready=%b, required 1", rdy_a);
        end
        audio_l      = l;
        audio_r      = r;
        sample_valid = 1'b1;
        @(negedge clk32);
        sample_valid = 1'b0;
        held_w       = pair_word(l, r);
        held_valid   = 1'b1;
    endtask

    // Runs one frame through the model, then decodes the next loaded frame from the pins.
    task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input bit push, input bit fmt, input bit mt, input bit flip);
        logic [31:0] w, wb, pb, exp_a, exp_b, got_a, got_b, got_ws;
        logic        ur0, ur0b, ur1, st1;
        bit          exp_ur, ok;
        if (push) push_pair(l, r);
        exp_ur = !held_valid;
        if (mt)              w = '0;
        else if (held_valid) w = held_w;
        else                 w = prev_w;
        held_valid = 1'b0;
        wb    = w ^ 32'h8000_8000;
        pb    = prev_w ^ 32'h8000_8000;
        exp_a = fmt ? {prev_w[0], w[31:1]} : w;
        exp_b = fmt ? {pb[0], wb[31:1]} : wb;
        fmt_i2s = fmt;
        mute    = mt;
        wait_strobe(ok);
        ur0  = ur_a;
        ur0b = ur_b;
        @(negedge clk32);
        ur1 = ur_a;
        st1 = stb_a;
        got_a = '0; got_b = '0; got_ws = '0;
        for (int k = 0; k < 32; k++) begin
            wait_bck_rise(ok);
            got_a  = {got_a[30:0], din_a};
            got_b  = {got_b[30:0], din_b};
            got_ws = {got_ws[30:0], ws_a};
            if (flip && k == 8) fmt_i2s = ~fmt_i2s;
        end
        vectors++;
        if (got_a !== exp_a) begin
            miscompares++;
            $display("FAIL %s data_lin: got %h, required %h", tag, got_a, exp_a);
        end
        vectors++;
        if (got_b !== exp_b) begin
            miscompares++;
            $display("FAIL %s data_offset: got %h, required %h", tag, got_b, exp_b);
        end
        vectors++;
        if (got_ws !== 32'h0000_FFFF) begin
            miscompares++;
            $display("FAIL %s ws: got %h, required 0000ffff", tag, got_ws);
        end
        vectors++;
        if (ur0 !== exp_ur || ur0b !== exp_ur) begin
            miscompares++;
            $display("FAIL %s underrun: got %b/%b, required %b", tag, ur0, ur0b, exp_ur);
        end
        vectors++;
        if (ur1 !== 1'b0 || st1 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse_width: underrun=%b strobe=%b a cycle later, required 0/0",
                     tag, ur1, st1);
        end
        prev_w = w;
    endtask

    task automatic test_reset();
        por = 1'b1; sample_valid = 1'b0; fmt_i2s = 1'b0; mute = 1'b0;
        audio_l = '0; audio_r = '0;
        repeat (3) @(negedge clk32);
        vectors++;
        if ({bck_a, ws_a, din_a, stb_a, ur_a, rdy_a} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_lin: outputs %b, required 000000",
                     {bck_a, ws_a, din_a, stb_a, ur_a, rdy_a});
        end
        vectors++;
        if ({bck_b, ws_b, din_b, stb_b, ur_b, rdy_b} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_offset: outputs %b, required 000000",
                     {bck_b, ws_b, din_b, stb_b, ur_b, rdy_b});
        end
        por = 1'b0;
        #1;
        vectors++;
        if (rdy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b, required 0", rdy_a);
        end
        @(negedge clk32);
        vectors++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b/%b, required 1/1", rdy_a, rdy_b);
        end
        prev_w = '0;
        held_valid = 1'b0;
        run_frame("first_frame_silence", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timing();
        bit ok;
        logic p;
        int unsigned cnt;
        wait_strobe(ok);
        p = stb_a; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk32);
            cnt++;
            if (stb_a && !p) break;
            p = stb_a;
        end
        vectors++;
        if (cnt != 1280) begin
            miscompares++;
            $display("FAIL frame_period: got %0d cycles, required 1280", cnt);
        end
        wait_bck_rise(ok);
        p = bck_a; cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk32);
            cnt++;
            if (bck_a && !p) break;
            p = bck_a;
        end
        vectors++;
        if (cnt != 40) begin
            miscompares++;
            $display("FAIL bck_period: got %0d cycles, required 40", cnt);
        end
    endtask

    task automatic test_left_justified();
        run_frame("lj_1234_abcd", 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("lj_0000_7fff", 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_philips();
        run_frame("i2s_8001", 16'h8001, 16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("i2s_second", 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        run_frame("underrun_repeat", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_push_at_load();
        bit ok;
        mute = 1'b0;
        wait_strobe(ok);
        repeat (1279) @(negedge clk32);
        audio_l = 16'h5A5A; audio_r = 16'hC3C3; sample_valid = 1'b1;
        @(negedge clk32);
        sample_valid = 1'b0;
        vectors++;
        if (stb_a !== 1'b1 || ur_a !== 1'b1 || rdy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL push_at_load: strobe=%b underrun=%b ready=%b, required 1 1 0",
                     stb_a, ur_a, rdy_a);
        end
        held_w = pair_word(16'h5A5A, 16'hC3C3);
        held_valid = 1'b1;
        run_frame("push_at_load_next", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mute();
        run_frame("mute_load", 16'h7123, 16'h8456, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame("mute_consumed", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fmt_midframe();
        run_frame("fmt_flip_mid", 16'h9C3A, 16'h1F0E, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame("fmt_next_frame", 16'h6B2D, 16'hE417, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit push, fmt, mt;
        for (int i = 0; i < 6; i++) begin
            push = ($urandom_range(0, 3) != 0);
            fmt  = 1'($urandom_range(0, 1));
            mt   = push && ($urandom_range(0, 4) == 0);
            run_frame("random", 16'($urandom), 16'($urandom), push, fmt, mt, 1'b0);
        end
    endtask

    task automatic test_por_midframe();
        bit ok;
        wait_strobe(ok);
        push_pair(16'h4321, 16'h8765);
        repeat (289) @(negedge clk32);
        por = 1'b1;
        #1;
        vectors++;
        if ({bck_a, ws_a, din_a, stb_a, ur_a, rdy_a, bck_b, ws_b, din_b, stb_b, ur_b, rdy_b}
            !== 12'b0) begin
            miscompares++;
            $display("FAIL por_midframe: outputs %b %b, required all 0",
                     {bck_a, ws_a, din_a, stb_a, ur_a, rdy_a},
                     {bck_b, ws_b, din_b, stb_b, ur_b, rdy_b});
        end
        repeat (3) @(negedge clk32);
        por = 1'b0;
        @(negedge clk32);
        vectors++;
        if (rdy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL por_ready: got %b, required 1", rdy_a);
        end
        prev_w = '0;
        held_valid = 1'b0;
        run_frame("after_por_silence", 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

`ifdef I2S_TX_MONO_MIX_EN
    task automatic test_mono();
        mono = 1'b1;
        run_frame("mono_7fff_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("mono_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        mono = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_left_justified();
        test_philips();
        test_underrun();
        test_push_at_load();
        test_mute();
        test_fmt_midframe();
        test_random();
`ifdef I2S_TX_MONO_MIX_EN
        test_mono();
`endif
        test_por_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_HZ, 32000000, clk32 frequency.
- SAMPLE_RATE, 24000, nominal frame rate.
- SAMPLE_W, 16, sample width.
- SLOT_W, 16, bits per channel slot; SLOT_W >= SAMPLE_W.
- OFFSET_BIN, 1, invert MSB on output (offset-binary DAC).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk32  in  1  only clock.
- por  in  1  reset; asynchronous, active-high.
- audio_l  in  SAMPLE_W  left sample, signed.
- audio_r  in  SAMPLE_W  right sample, signed.
- sample_valid  in  1  sample pair offered.
- sample_ready  out  1  holding register empty.
- fmt_i2s  in  1  1 = Philips I2S (1-bit delay), 0 = left-justified.
- mute  in  1  load silence at the next frame.
- i2s_bck  out  1  bit clock.
- i2s_ws  out  1  word select; 0 = left.
- i2s_din  out  1  serial data.
- frame_strobe  out  1  one-clk32 pulse at each frame load.
- underrun  out  1  one-clk32 pulse when a frame loads with no new sample.

Function
REQ-003 DIV SHALL equal CLK_HZ/(SAMPLE_RATE*2*SLOT_W*2), using integer truncation; DIV < 1 SHALL be an elaboration error.
REQ-004 div_cnt SHALL count 0..DIV-1; at DIV-1 it SHALL wrap and toggle i2s_bck, which is registered, so each bck period is 2*DIV clk32 cycles.
REQ-005 bit_cnt (0..2*SLOT_W-1) SHALL advance on each cycle where i2s_bck toggles 1->0, and SHALL wrap to 0.
- i2s_ws and i2s_din SHALL change only on these falling-edge cycles.
REQ-006 The frame load SHALL occur on the falling edge where bit_cnt wraps to 0; frame_strobe SHALL pulse in that same cycle.
REQ-007 The holding register SHALL accept a sample pair when sample_valid && sample_ready, which sets it full.
- sample_ready SHALL equal !full, registered.
REQ-008 At a frame load with holding full:
- The shift words SHALL take the holding contents.
- The holding register SHALL become empty.
- If a handshake occurs in the same cycle, the new pair SHALL be captured into holding and holding SHALL remain full.
REQ-009 At a frame load with holding empty, the previous shift words SHALL be reused unchanged and underrun SHALL pulse.
REQ-010 If mute=1 at a frame load, the loaded words SHALL be zero before encoding; the holding register SHALL still be consumed.
REQ-011 Encoding per slot:
- SAMPLE_W sample bits MSB first, then SLOT_W-SAMPLE_W zero pad bits.
- With OFFSET_BIN=1, the sample MSB SHALL be inverted.
REQ-012 fmt_i2s=0 (left-justified):
- i2s_ws = (bit_cnt >= SLOT_W).
- The slot MSB SHALL appear at bit_cnt 0 (left) and at bit_cnt SLOT_W (right).
REQ-013 fmt_i2s=1 (Philips I2S):
- i2s_ws SHALL toggle one bck before the slot MSB.
- The data stream SHALL be delayed by one bck; the first bit of the left slot carries the last bit of the previous right slot.
REQ-014 fmt_i2s SHALL be sampled only at frame load, so a change mid-frame takes effect at the next frame.

Reset
REQ-015 While por=1, all registers SHALL clear asynchronously:
- i2s_bck, i2s_ws, i2s_din, frame_strobe, underrun, sample_ready, div_cnt, bit_cnt = 0.
- Holding register empty.
- Shift words = encoded silence (0x8000 with OFFSET_BIN=1 and SAMPLE_W=16).
REQ-016 sample_ready SHALL rise on the first clk32 edge after por deasserts.
REQ-017 After por deasserts, the first frame SHALL transmit encoded silence.
REQ-018 por asserted mid-frame SHALL abort the frame immediately, with no partial load preserved.

Configuration
REQ-019 With I2S_TX_MONO_MIX_EN defined:
- An input port mono (1 bit) SHALL exist.
- When mono=1 at frame load, both slots SHALL carry (audio_l+audio_r)>>>1, computed in SAMPLE_W+1 bits with no wrap-around.
REQ-020 Without I2S_TX_MONO_MIX_EN, no mono port SHALL exist and the slots SHALL carry L and R independently.

Verification
REQ-021 Defaults, OFFSET_BIN=0, fmt_i2s=0, push L=0x1234 R=0xABCD -> bck period 40 clk32 cycles; frame 1280 cycles; ws=0 while 0x1234 is shifted MSB first; ws=1 while 0xABCD is shifted.
REQ-022 OFFSET_BIN=1, push L=0x0000 R=0x7FFF -> serial words 0x8000 and 0xFFFF.
REQ-023 fmt_i2s=1, L=0x8001 -> ws falls one bck before the left MSB; the MSB appears on the second bck of the left slot.
REQ-024 No sample_valid for one frame -> underrun pulses for exactly 1 cycle and the previous words repeat; a push in the same cycle as the load -> sample accepted and ready=0 afterward.
REQ-025 por pulse at bit_cnt=7 -> all outputs 0 within the same cycle; the next frame after release carries silence.
REQ-026 I2S_TX_MONO_MIX_EN defined, mono=1: L=R=0x7FFF -> both slots 0x7FFF; L=0x8000 R=0x7FFF -> both slots 0xFFFF.
